// File: rtl/collision_pkg.sv
// Shared constants for the sprite-vs-tile collision engine: side indices,
// scanner FSM states and default sprite/tile geometry.
package collision_pkg;

  localparam int SIDE_DOWN  = 0;
  localparam int SIDE_UP    = 1;
  localparam int SIDE_RIGHT = 2;
  localparam int SIDE_LEFT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_X_W        = 10;
  localparam int DEF_Y_W        = 9;
  localparam int DEF_N_TILES    = 16;
  localparam int DEF_A_W        = 4;
  localparam int DEF_TILE_W     = 25;
  localparam int DEF_TILE_H     = 24;
  localparam int DEF_SPR_H      = 41;
  localparam int DEF_FOOT_L     = 12;
  localparam int DEF_FOOT_R     = 30;
  localparam int DEF_DOWN_DEPTH = 4;
  localparam int DEF_SIDE_X     = 45;
  localparam int DEF_SIDE_TOP   = 2;
  localparam int DEF_SIDE_BOT   = 40;

endpackage

// File: rtl/collision_scanner_if.sv
// Scan request/result handshake plus the tile table read port.
// slave = scanner side, master = client (motion FSM + tile memory) side.
interface collision_scanner_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int A_W = 4
);
  logic           start;
  logic [X_W-1:0] x_sprite;
  logic [Y_W-1:0] y_sprite;
  logic           busy;
  logic           done;
  logic [3:0]     is_collision;
  logic [A_W:0]   hit_count;
  logic [Y_W-1:0] floor_y;
  logic [A_W-1:0] tile_addr;
  logic [X_W-1:0] tile_x;
  logic [Y_W-1:0] tile_y;
  logic           tile_en;

  modport slave (
    input  start, x_sprite, y_sprite, tile_x, tile_y, tile_en,
    output busy, done, is_collision, hit_count, floor_y, tile_addr
  );

  modport master (
    output start, x_sprite, y_sprite, tile_x, tile_y, tile_en,
    input  busy, done, is_collision, hit_count, floor_y, tile_addr
  );
endinterface

// File: rtl/collision_scanner_tile_side_test.sv
// Combinational four-side overlap test of one sprite against one tile.
// All sums are widened by one bit so coordinates near the top never alias.
import collision_pkg::*;

module tile_side_test #(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int TILE_W     = DEF_TILE_W,
  parameter int TILE_H     = DEF_TILE_H,
  parameter int SPR_H      = DEF_SPR_H,
  parameter int FOOT_L     = DEF_FOOT_L,
  parameter int FOOT_R     = DEF_FOOT_R,
  parameter int DOWN_DEPTH = DEF_DOWN_DEPTH,
  parameter int SIDE_X     = DEF_SIDE_X,
  parameter int SIDE_TOP   = DEF_SIDE_TOP,
  parameter int SIDE_BOT   = DEF_SIDE_BOT
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] tx,
  input  logic [Y_W-1:0] ty,
  output logic [3:0]     flags
);

  localparam logic [X_W:0] TW = (X_W+1)'(TILE_W);
  localparam logic [X_W:0] FL = (X_W+1)'(FOOT_L);
  localparam logic [X_W:0] FR = (X_W+1)'(FOOT_R);
  localparam logic [X_W:0] SX = (X_W+1)'(SIDE_X);
  localparam logic [Y_W:0] TH = (Y_W+1)'(TILE_H);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SPR_H);
  localparam logic [Y_W:0] DD = (Y_W+1)'(DOWN_DEPTH);
  localparam logic [Y_W:0] ST = (Y_W+1)'(SIDE_TOP);
  localparam logic [Y_W:0] SB = (Y_W+1)'(SIDE_BOT);

  logic [X_W:0] xs, txs, tx_end;
  logic [Y_W:0] ys, tys, ty_end;
  logic         span, vert;

  always_comb begin
    xs     = {1'b0, x};
    txs    = {1'b0, tx};
    ys     = {1'b0, y};
    tys    = {1'b0, ty};
    tx_end = txs + TW;
    ty_end = tys + TH;

    span = (xs + FR > txs) && (xs + FL < tx_end);
    vert = (ys + ST <= ty_end) && (ys + SB >= tys);

    flags             = '0;
    flags[SIDE_DOWN]  = span && (ys + SH >= tys) && (ys + SH + DD <= ty_end);
    flags[SIDE_UP]    = span && (ys >= tys) && (ys <= ty_end);
    flags[SIDE_RIGHT] = vert && (xs + SX >= txs) && (xs + SX <= tx_end);
    flags[SIDE_LEFT]  = vert && (xs >= txs) && (xs <= tx_end);
  end

endmodule

// File: rtl/collision_scanner.sv
// Streams the tile table once per start pulse and accumulates the side mask,
// hit count and landing floor for the latched sprite position.
import collision_pkg::*;

module collision_scanner #(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int N_TILES    = DEF_N_TILES,
  parameter int A_W        = DEF_A_W,
  parameter int TILE_W     = DEF_TILE_W,
  parameter int TILE_H     = DEF_TILE_H,
  parameter int SPR_H      = DEF_SPR_H,
  parameter int FOOT_L     = DEF_FOOT_L,
  parameter int FOOT_R     = DEF_FOOT_R,
  parameter int DOWN_DEPTH = DEF_DOWN_DEPTH,
  parameter int SIDE_X     = DEF_SIDE_X,
  parameter int SIDE_TOP   = DEF_SIDE_TOP,
  parameter int SIDE_BOT   = DEF_SIDE_BOT
) (
  input logic                clk,
  input logic                rst_n,
  collision_scanner_if.slave bus
);

  localparam logic [A_W-1:0] LAST_ADDR = A_W'(N_TILES - 1);
  localparam logic [A_W:0]   CNT_MAX   = (A_W+1)'(N_TILES);

  state_t         state, state_nxt;
  logic           busy, done, accept, vld;
  logic [X_W-1:0] x_lat;
  logic [Y_W-1:0] y_lat;
  logic [A_W-1:0] addr;
  logic [3:0]     flags;
  logic [3:0]     mask_acc, mask_nxt, mask_out;
  logic [A_W:0]   cnt_acc, cnt_nxt, cnt_out;
  logic [Y_W-1:0] floor_acc, floor_nxt, floor_out;

  tile_side_test #(
    .X_W(X_W), .Y_W(Y_W), .TILE_W(TILE_W), .TILE_H(TILE_H), .SPR_H(SPR_H),
    .FOOT_L(FOOT_L), .FOOT_R(FOOT_R), .DOWN_DEPTH(DOWN_DEPTH),
    .SIDE_X(SIDE_X), .SIDE_TOP(SIDE_TOP), .SIDE_BOT(SIDE_BOT)
  ) u_side_test (
    .x(x_lat), .y(y_lat), .tx(bus.tile_x), .ty(bus.tile_y), .flags(flags)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_nxt  = mask_acc;
    cnt_nxt   = cnt_acc;
    floor_nxt = floor_acc;
    if (vld && bus.tile_en) begin
      mask_nxt = mask_acc | flags;
      if ((|flags) && (cnt_acc < CNT_MAX)) cnt_nxt = cnt_acc + 1'b1;
      if (flags[SIDE_DOWN] && (bus.tile_y < floor_acc)) floor_nxt = bus.tile_y;
    end
  end

  // Outputs load from the next-accumulator values in DRAIN so the last tile
  // is already included when done is asserted in the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      vld       <= 1'b0;
      x_lat     <= '0;
      y_lat     <= '0;
      mask_acc  <= '0;
      cnt_acc   <= '0;
      floor_acc <= '1;
      mask_out  <= '0;
      cnt_out   <= '0;
      floor_out <= '1;
    end else begin
      state <= state_nxt;
      vld   <= (state == ST_SCAN);
      if (accept) begin
        x_lat     <= bus.x_sprite;
        y_lat     <= bus.y_sprite;
        addr      <= '0;
        mask_acc  <= '0;
        cnt_acc   <= '0;
        floor_acc <= '1;
      end else begin
        if (state == ST_SCAN) addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        if (vld) begin
          mask_acc  <= mask_nxt;
          cnt_acc   <= cnt_nxt;
          floor_acc <= floor_nxt;
        end
      end
      if (state == ST_DRAIN) begin
        mask_out  <= mask_nxt;
        cnt_out   <= cnt_nxt;
        floor_out <= floor_nxt;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.tile_addr    = addr;
  assign bus.is_collision = mask_out;
  assign bus.hit_count    = cnt_out;
  assign bus.floor_y      = floor_out;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a synchronous 16-entry tile table
// model; expected values are hand-computed from the default geometry.
module tb_collision_scanner;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] mx [N];
  logic [8:0] my [N];
  logic       me [N];

  collision_scanner_if #(.X_W(10), .Y_W(9), .A_W(4)) bus ();

  collision_scanner #(
    .X_W(10), .Y_W(9), .N_TILES(N), .A_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.tile_x  <= mx[bus.tile_addr];
    bus.tile_y  <= my[bus.tile_addr];
    bus.tile_en <= me[bus.tile_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tiles();
    for (int i = 0; i < N; i++) begin
      mx[i] = '0;
      my[i] = '0;
      me[i] = 1'b0;
    end
  endtask

  task automatic set_tile(input int idx, input int tx, input int ty, input logic en);
    mx[idx] = 10'(tx);
    my[idx] = 9'(ty);
    me[idx] = en;
  endtask

  // Pulses start for one cycle and returns the cycle number done was seen in
  // (cycle 1 = first cycle after the accepting edge), or -1 on timeout.
  task automatic scan(input int sx, input int sy, output int lat);
    @(negedge clk);
    bus.x_sprite = 10'(sx);
    bus.y_sprite = 9'(sy);
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input int lat, input int mask,
                               input int cnt, input int fl);
    check({tag, "_latency"}, lat, N + 2);
    check({tag, "_mask"}, bus.is_collision, mask);
    check({tag, "_count"}, bus.hit_count, cnt);
    check({tag, "_floor"}, bus.floor_y, fl);
  endtask

  initial begin
    int lat;
    int dones;
    int first_done;
    int second_done;

    bus.start    = 1'b0;
    bus.x_sprite = '0;
    bus.y_sprite = '0;
    clear_tiles();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_mask", bus.is_collision, 0);
    check("reset_count", bus.hit_count, 0);
    check("reset_floor", bus.floor_y, 9'h1ff);
    check("reset_addr", bus.tile_addr, 0);

    // Single landing tile
    set_tile(0, 110, 101, 1'b1);
    scan(100, 60, lat);
    check_results("land", lat, 4'b0001, 1, 101);
    check("land_busy_at_done", bus.busy, 0);
    @(negedge clk);
    check("land_done_pulse", bus.done, 0);

    // Two down hits plus a disabled tile that would otherwise lower the floor
    clear_tiles();
    set_tile(0, 110, 103, 1'b1);
    set_tile(5, 110, 101, 1'b1);
    set_tile(9, 110, 90, 1'b0);
    scan(100, 62, lat);
    check_results("two_down", lat, 4'b0001, 2, 101);

    // Right wall at the last table entry
    clear_tiles();
    set_tile(15, 140, 70, 1'b1);
    scan(100, 60, lat);
    check_results("right", lat, 4'b0100, 1, 9'h1ff);

    clear_tiles();
    set_tile(0, 80, 70, 1'b1);
    scan(100, 60, lat);
    check_results("left", lat, 4'b1000, 1, 9'h1ff);

    clear_tiles();
    set_tile(3, 110, 50, 1'b1);
    scan(100, 60, lat);
    check_results("up", lat, 4'b0010, 1, 9'h1ff);

    // Sprite near the right edge must not alias onto a tile at small x
    clear_tiles();
    set_tile(0, 5, 60, 1'b1);
    scan(1020, 60, lat);
    check_results("nowrap", lat, 4'b0000, 0, 9'h1ff);

    // Every tile hits: count reaches N_TILES
    for (int i = 0; i < N; i++) set_tile(i, 110, 101, 1'b1);
    scan(100, 60, lat);
    check_results("all_hit", lat, 4'b0001, N, 101);

    // Reset during a scan
    @(negedge clk);
    bus.x_sprite = 10'd100;
    bus.y_sprite = 9'd60;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_mask", bus.is_collision, 0);
    check("midrst_count", bus.hit_count, 0);
    check("midrst_floor", bus.floor_y, 9'h1ff);
    check("midrst_addr", bus.tile_addr, 0);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);

    // Start held high: one done per scan, back-to-back restart after done,
    // outputs held and x_sprite ignored during the second scan
    clear_tiles();
    set_tile(0, 110, 101, 1'b1);
    @(negedge clk);
    bus.x_sprite = 10'd100;
    bus.y_sprite = 9'd60;
    bus.start    = 1'b1;
    @(posedge clk);
    dones       = 0;
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = c;
          check("hs_first_mask", bus.is_collision, 4'b0001);
          set_tile(0, 140, 70, 1'b1);
        end else begin
          second_done = c;
          bus.start = 1'b0;
          break;
        end
      end
      if (c == N + 3) check("hs_idle_gap_busy", bus.busy, 0);
      if (c == N + 4) check("hs_restart_busy", bus.busy, 1);
      if (c == N + 8) begin
        bus.x_sprite = 10'd0;
        check("hs_held_mask", bus.is_collision, 4'b0001);
        check("hs_held_floor", bus.floor_y, 101);
      end
    end
    bus.start = 1'b0;
    check("hs_first_latency", first_done, N + 2);
    check("hs_second_latency", second_done, 2 * N + 5);
    check("hs_done_count", dones, 2);
    check("hs_second_mask", bus.is_collision, 4'b0100);
    check("hs_second_floor", bus.floor_y, 9'h1ff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
